// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and default widths for the register file and decode
package reg_file_pkg;
   typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;
   localparam int RF_W = 8;
   localparam int RF_PW = 4;
endpackage

// File: rtl/rf_clear_ctrl.sv
// rf_clear_ctrl: post-reset clear sequencer, owns ready and the dropped-write flag
module rf_clear_ctrl
   import reg_file_pkg::*;
#(
   parameter int PW = RF_PW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_req,
   output logic          clr_en,
   output logic [PW-1:0] clr_addr,
   output logic          ready,
   output logic          wr_err
);
   localparam logic [PW:0] LAST = (PW+1)'(2**PW - 1);
   rf_state_t   state;
   logic [PW:0] clr_ptr;
   always_ff @(posedge clk)
      if (reset) begin
         state   <= RF_CLEAR;
         clr_ptr <= '0;
         ready   <= 1'b0;
         wr_err  <= 1'b0;
      end else begin
         wr_err <= wr_req && !ready;
         if (state == RF_CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == LAST) begin
               state <= RF_READY;
               ready <= 1'b1;
            end
         end
      end
   assign clr_en   = (state == RF_CLEAR) && !reset;
   assign clr_addr = clr_ptr[PW-1:0];
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with bypass, optional zero register and post-reset clear
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int W       = RF_W,
   parameter int PW      = RF_PW,
   parameter int NR      = 2,
   parameter int BYPASS  = 1,
   parameter int R0_ZERO = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [PW-1:0]         wr_addr,
   input  logic [W-1:0]          wr_dat,
   input  logic [NR-1:0][PW-1:0] rd_addr,
   output logic [NR-1:0][W-1:0]  rd_dat,
   output logic                  ready,
   output logic                  wr_err
);
   localparam int D = 2**PW;
   logic [W-1:0]  core [D];
   logic          r0_hit, wr_ok, clr_en;
   logic [PW-1:0] clr_addr;
   assign r0_hit = (R0_ZERO != 0) && (wr_addr == '0);
   assign wr_ok  = ready && wr_en && !reset && !r0_hit;
   rf_clear_ctrl #(.PW(PW)) u_ctrl (
      .clk(clk),
      .reset(reset),
      .wr_req(wr_en && !r0_hit),
      .clr_en(clr_en),
      .clr_addr(clr_addr),
      .ready(ready),
      .wr_err(wr_err)
   );
   always_ff @(posedge clk)
      if (clr_en) core[clr_addr] <= '0;
      else if (wr_ok) core[wr_addr] <= wr_dat;
   genvar i;
   generate
      for (i = 0; i < NR; i++) begin : g_rd
         logic zero_hit, byp_hit;
         assign zero_hit  = !ready || ((R0_ZERO != 0) && (rd_addr[i] == '0));
         assign byp_hit   = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr[i]);
         assign rd_dat[i] = zero_hit ? '0 : byp_hit ? wr_dat : core[rd_addr[i]];
      end
   endgenerate
endmodule
